fir_decim_buffer: RTL and testbench
===================================

// Module: fir_decim_buffer
// PURPOSE
// Downstream stage of fir_filter: consumes its signed 16-bit y_out stream, decimates by
// 2**DECIM_LOG2 (accumulate-and-dump average), rounds/scales and saturates to signed 8 bits.
// Results are buffered in a small first-word-fall-through FIFO with a valid/ready output,
// so a slower consumer (DAC/UART packer) can drain them.
// PARAMETERS
// IN_W        16  input sample width (matches fir_filter y_out)
// OUT_W       8   output sample width
// DECIM_LOG2  1   decimation factor = 2**DECIM_LOG2 (1..4)
// SHIFT       4   post-average right shift with round-half-up (>=1)
// DEPTH       4   FIFO entries (power of two, >=2)
// PORTS
// clk         in   1                     rising-edge clock
// reset       in   1                     synchronous, active-high reset
// y_in        in   IN_W signed           filter output sample
// y_valid     in   1                     y_in valid this cycle
// out_data    out  OUT_W signed          FIFO head sample
// out_valid   out  1                     FIFO non-empty
// out_ready   in   1                     consumer accepts out_data
// fifo_count  out  $clog2(DEPTH+1)       entries held
// overflow    out  1                     sticky: a result was dropped
// BEHAVIOUR
// - Single clock clk; reset synchronous active-high, sampled on rising edge only.
// - Reset: phase counter=0, accumulator=0, dump stage empty, FIFO empty; out_valid=0,
//   out_data=0, fifo_count=0, overflow=0. Reset mid-group discards partial sum.
// - Phase counter advances only on y_valid; gaps in y_valid hold state. Accumulator width
//   IN_W+DECIM_LOG2. Phase 0 loads y_in; others add y_in.
// - Group-complete (phase==2**DECIM_LOG2-1 with y_valid) at edge k: full sum captured into dump
//   register, counter wraps to 0, accumulator restarts with next sample (no lost samples).
// - Edge k+1: avg = sum >>> DECIM_LOG2 (arithmetic, floor);
//   r = (avg + 2**(SHIFT-1)) >>> SHIFT; sat to [-2**(OUT_W-1), 2**(OUT_W-1)-1]; pushed to FIFO.
//   With FIFO empty, out_valid=1 and out_data=r after edge k+1 (latency 2 edges incl. capture).
// - FIFO: FWFT; out_data = head whenever out_valid=1 (out_data holds last value/0 when empty,
//   don't-care to consumer). Pop on out_valid&&out_ready. Order strictly preserved.
// - Full (count==DEPTH) push without same-cycle pop: result dropped, overflow set, stays 1
//   until reset. Push and pop same cycle when full: both occur, count unchanged, no overflow.
// - Push and pop same cycle when empty is impossible (out_valid=0); push only.
// - out_ready while empty ignored. y_valid arriving every cycle supported at full rate.
// TESTING (defaults unless noted)
// 1 reset 2 cycles, out_ready=1 -> out_valid=0, fifo_count=0, overflow=0, out_data=0.
// 2 y_in=100,200 back-to-back valid -> avg 150, out_data=9 one edge after 2nd capture, then pops.
// 3 y_in=-100,-101 -> avg -101, out_data=-6; y_in=5000,5000 -> 127; -5000,-5000 -> -128.
// 4 out_ready=0, 5 groups of (16,16) -> fifo_count=4, overflow=1; out_ready=1 -> four 1s drained
//   in order, fifo_count->0, overflow stays 1.
// 5 FIFO full, pop and push same cycle -> fifo_count stays 4, overflow stays 0, order intact.
// 6 y_in=400 valid, reset 1 cycle, then y_in=32,32 with idle y_valid gap between -> exactly one
//   output, out_data=2; no output from pre-reset sample.

Source files
------------

// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer
//   Decimating back end for the FIR filter output stream. Sums groups of
//   2**DECIM_LOG2 valid samples and averages them (floor). The average is then
//   rounded half-up, scaled down by SHIFT bits, saturated to OUT_W signed bits,
//   and pushed into a first-word-fall-through FIFO that has a valid/ready drain.
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   y_in        signed input sample, qualified by y_valid
//   y_valid     input sample valid
//   out_data    FIFO head sample (0 while empty)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts out_data; ignored while empty
//   fifo_count  entries currently held
//   overflow    sticky: a result was dropped because the FIFO was full
module fir_decim_buffer #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int DECIM_LOG2 = 1,
  parameter int SHIFT      = 4,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [IN_W-1:0]         y_in,
  input  logic                           y_valid,
  output logic signed [OUT_W-1:0]        out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
  output logic                           overflow
);

  localparam int ACC_W = IN_W + DECIM_LOG2;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Post-average arithmetic runs one bit wider than the accumulator so the
  // rounding constant can never wrap the sum.
  localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(2**(SHIFT-1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(OUT_W-1)));

  // ---------------- accumulate and dump ----------------
  logic [DECIM_LOG2-1:0]     r_phase;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_dump;
  logic                      r_dump_vld;
  logic signed [ACC_W-1:0]   w_y_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic                      w_last;

  assign w_y_ext = {{DECIM_LOG2{y_in[IN_W-1]}}, y_in};
  assign w_sum   = r_acc + w_y_ext;
  assign w_last  = &r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase    <= '0;
      r_acc      <= '0;
      r_dump     <= '0;
      r_dump_vld <= 1'b0;
    end else begin
      r_dump_vld <= y_valid && w_last;
      if (y_valid) begin
        // Phase counter wraps naturally at 2**DECIM_LOG2; phase 0 reloads the
        // accumulator, so the sample after a dump starts the next group.
        r_phase <= r_phase + 1'b1;
        r_acc   <= (r_phase == '0) ? w_y_ext : w_sum;
        if (w_last)
          r_dump <= w_sum;
      end
    end
  end

  // ---------------- average, round, saturate ----------------
  logic signed [ACC_W:0]     w_dump_ext;
  logic signed [ACC_W:0]     w_avg;
  logic signed [ACC_W:0]     w_rnd;
  logic signed [ACC_W:0]     w_q;
  logic signed [OUT_W-1:0]   w_sat;

  assign w_dump_ext = {r_dump[ACC_W-1], r_dump};
  assign w_avg      = w_dump_ext >>> DECIM_LOG2;
  assign w_rnd      = w_avg + RND;
  assign w_q        = w_rnd >>> SHIFT;

  always_comb begin
    w_sat = w_q[OUT_W-1:0];
    if (w_q > SAT_MAX)
      w_sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_q < SAT_MIN)
      w_sat = {1'b1, {(OUT_W-1){1'b0}}};
  end

  // ---------------- FWFT FIFO ----------------
  logic signed [OUT_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic                      r_overflow;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_wr;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_pop  = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_wr   = r_dump_vld && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= w_sat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_dump_vld && !w_wr)
        r_overflow <= 1'b1;
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_fir_decim_buffer.sv
module tb_fir_decim_buffer;

  localparam int N     = 2;   // 2**DECIM_LOG2
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] y_in;
  logic               y_valid;
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         fifo_count;
  logic               overflow;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a list of samples in the current group, the result waiting
  // one edge before it reaches the FIFO, and the FIFO itself as a bounded queue.
  int grp[$];
  int mq[$];
  bit m_pend;
  int m_pend_val;
  bit m_ovf;

  fir_decim_buffer dut (
    .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic int fdiv(input int a, input int n);
    int q;
    q = a / n;
    if ((a % n != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int expect_group(input int s);
    int r;
    r = fdiv(fdiv(s, N) + 8, 16);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic model_clear();
    grp.delete();
    mq.delete();
    m_pend = 0;
    m_ovf  = 0;
  endtask

  // One clock: drive inputs, advance the model by the same edge, return #1 after it.
  task automatic cyc(input bit yv, input int y, input bit rdy);
    bit pop;
    bit nxt;
    int nval;
    int s;
    y_valid   = yv;
    y_in      = 16'(y);
    out_ready = rdy;
    pop  = (mq.size() != 0) && rdy;
    nxt  = 0;
    nval = 0;
    if (m_pend && mq.size() == DEPTH && !pop) m_ovf = 1;
    if (pop) void'(mq.pop_front());
    if (m_pend && mq.size() < DEPTH) mq.push_back(m_pend_val);
    if (yv) begin
      grp.push_back(y);
      if (grp.size() == N) begin
        s = 0;
        foreach (grp[i]) s += grp[i];
        nxt  = 1;
        nval = expect_group(s);
        grp.delete();
      end
    end
    m_pend     = nxt;
    m_pend_val = nval;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    y_valid   = 1'b0;
    y_in      = '0;
    out_ready = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset(2);
    n_vec++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || out_data !== 8'sd0) begin
      n_err++;
      $display("FAIL reset: valid=%b count=%0d ovf=%b data=%0d, want 0 0 0 0",
               out_valid, fifo_count, overflow, out_data);
    end
  endtask

  task automatic test_basic_avg();
    cyc(1, 100, 1);
    cyc(1, 200, 1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL avg_latency: valid=%b after capture, want 0", out_valid);
    end
    cyc(0, 0, 1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'sd9 || fifo_count !== 3'd1) begin
      n_err++;
      $display("FAIL avg_100_200: valid=%b data=%0d count=%0d, want 1 9 1", out_valid, out_data, fifo_count);
    end
    cyc(0, 0, 1);
    n_vec++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_err++; $display("FAIL avg_pop: valid=%b count=%0d, want 0 0", out_valid, fifo_count);
    end
  endtask

  task automatic test_round_sat();
    int ya[3];
    int yb[3];
    int want[3];
    ya = '{-100, 5000, -5000};
    yb = '{-101, 5000, -5000};
    want = '{-6, 127, -128};
    for (int i = 0; i < 3; i++) begin
      cyc(1, ya[i], 0);
      cyc(1, yb[i], 0);
      cyc(0, 0, 1);
      n_vec++;
      if (out_valid !== 1'b1 || $signed(out_data) !== want[i]) begin
        n_err++;
        $display("FAIL round_sat[%0d]: valid=%b data=%0d, want 1 %0d", i, out_valid, out_data, want[i]);
      end
      cyc(0, 0, 1);
    end
  endtask

  task automatic test_overflow();
    do_reset(1);
    for (int g = 0; g < 5; g++) begin
      cyc(1, 16, 0);
      cyc(1, 16, 0);
    end
    cyc(0, 0, 0);
    n_vec++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_fill: count=%0d ovf=%b, want 4 1", fifo_count, overflow);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'sd1) begin
        n_err++; $display("FAIL ovf_drain[%0d]: valid=%b data=%0d, want 1 1", k, out_valid, out_data);
      end
      cyc(0, 0, 1);
    end
    n_vec++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: count=%0d valid=%b ovf=%b, want 0 0 1", fifo_count, out_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset(1);
    for (int g = 1; g <= 4; g++) begin
      cyc(1, 16 * g, 0);
      cyc(1, 16 * g, 0);
    end
    cyc(1, 80, 0);
    cyc(1, 80, 0);
    n_vec++;
    if (fifo_count !== 3'd4) begin
      n_err++; $display("FAIL full_pre: count=%0d, want 4", fifo_count);
    end
    cyc(0, 0, 1);  // push of 5 and pop of 1 on the same edge
    n_vec++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      n_err++; $display("FAIL full_pushpop: count=%0d ovf=%b, want 4 0", fifo_count, overflow);
    end
    for (int k = 2; k <= 5; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || $signed(out_data) !== k) begin
        n_err++; $display("FAIL full_order: valid=%b data=%0d, want 1 %0d", out_valid, out_data, k);
      end
      cyc(0, 0, 1);
    end
  endtask

  task automatic test_reset_midgroup();
    int outs;
    do_reset(1);
    cyc(1, 400, 1);
    do_reset(1);
    cyc(1, 32, 1);
    cyc(0, 0, 1);
    cyc(1, 32, 1);
    cyc(0, 0, 1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'sd2) begin
      n_err++; $display("FAIL midreset: valid=%b data=%0d, want 1 2", out_valid, out_data);
    end
    outs = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 1);
      if (out_valid === 1'b1) outs++;
    end
    n_vec++;
    if (outs !== 0) begin
      n_err++; $display("FAIL midreset_extra: got %0d extra outputs, want 0", outs);
    end
  endtask

  task automatic test_random();
    do_reset(1);
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset(1);
      cyc($urandom_range(0, 9) < 7, int'($signed(16'($urandom))), $urandom_range(0, 1) == 1);
      n_vec++;
      if (out_valid !== (mq.size() != 0) || fifo_count !== 3'(mq.size()) || overflow !== m_ovf ||
          (mq.size() != 0 && out_data !== 8'(mq[0]))) begin
        n_err++;
        $display("FAIL random[%0d]: valid=%b count=%0d ovf=%b data=%0d, want %0d %0d %b %0d", c,
                 out_valid, fifo_count, overflow, out_data, mq.size() != 0, mq.size(), m_ovf,
                 (mq.size() != 0) ? mq[0] : 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; y_valid = 1'b0; y_in = '0; out_ready = 1'b1;
    model_clear();
    test_reset();
    test_basic_avg();
    test_round_sat();
    test_overflow();
    test_full_push_pop();
    test_reset_midgroup();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
